// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    // Which master was granted in the previous cycle.
    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    // Master indices used for the per-master return paths.
    localparam int M_CPU = 0;
    localparam int M_LDR = 1;

    // Byte write enables meaning "this is a read".
    localparam logic [3:0] WE_NONE = 4'b0000;

    // A granted access with no byte enables set is a read.
    function automatic logic is_read(input logic [3:0] we_in);
        return (we_in == WE_NONE);
    endfunction

endpackage

// File: rtl/arb_age_counter.sv
// Saturating wait counter for the low-priority master. Counts waiting
// cycles, clears on grant or when the request goes away, and flags when
// the limit is reached so the arbiter can force a grant.
module arb_age_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    input  logic [3:0] limit,
    output logic       expired
);

    logic [3:0] age_d;
    logic [3:0] age_q;

    // Next count: clear wins, otherwise count up until the limit.
    always_comb begin
        age_d = age_q;
        if (clr) begin
            age_d = 4'd0;
        end else if (inc && (age_q != limit)) begin
            age_d = age_q + 4'd1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            age_q <= 4'd0;
        end else begin
            age_q <= age_d;
        end
    end

    assign expired = (age_q == limit);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the shared data memory. The CPU port (master 0)
// has fixed priority; the loader port (master 1) is forced through after
// waiting STARVE_LIMIT cycles. Read data comes back one cycle after grant
// through a per-master capture register.
import dmem_arb_pkg::*;

module dmem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    // master 0: CPU data port
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [3:0]    m0_we,
    output logic          m0_gnt,
    output logic          m0_stall,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_rvalid,
    // master 1: loader / debug port
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [3:0]    m1_we,
    output logic          m1_gnt,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_rvalid,
    // data memory side
    output logic [AW-1:0] daddr,
    output logic [DW-1:0] dwdata,
    output logic [3:0]    we,
    input  logic [DW-1:0] drdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic             expired;
    logic             age_inc;
    logic             age_clr;
    owner_e           owner_d;
    owner_e           owner_q;
    logic             rd_d;
    logic             rd_q;
    logic [1:0]       gnt_v;
    logic [1:0][3:0]  we_v;
    logic [1:0]       rvalid_v;

    // Grant decision: CPU first unless the loader has aged out; nothing
    // is granted while reset is asserted.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst) begin
            if (m1_req && (expired || !m0_req)) begin
                m1_gnt = 1'b1;
            end else if (m0_req) begin
                m0_gnt = 1'b1;
            end
        end
    end

    assign m0_stall = m0_req & ~m0_gnt;

    // Steer the granted master onto the memory port; idle drives zeros.
    always_comb begin
        daddr  = '0;
        dwdata = '0;
        we     = WE_NONE;
        if (m0_gnt) begin
            daddr  = m0_addr;
            dwdata = m0_wdata;
            we     = m0_we;
        end else if (m1_gnt) begin
            daddr  = m1_addr;
            dwdata = m1_wdata;
            we     = m1_we;
        end
    end

    assign age_inc = m1_req & ~m1_gnt;
    assign age_clr = m1_gnt | ~m1_req;

    arb_age_counter u_age (
        .clk     (clk),
        .rst     (rst),
        .inc     (age_inc),
        .clr     (age_clr),
        .limit   (LIMIT),
        .expired (expired)
    );

    // Remember who was granted and whether it was a read, for routing rvalid.
    always_comb begin
        owner_d = OWN_IDLE;
        if (m0_gnt) begin
            owner_d = OWN_M0;
        end else if (m1_gnt) begin
            owner_d = OWN_M1;
        end
        rd_d = (owner_d != OWN_IDLE) && is_read(we);
    end

    // Owner and read-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_IDLE;
            rd_q    <= 1'b0;
        end else begin
            owner_q <= owner_d;
            rd_q    <= rd_d;
        end
    end

    assign gnt_v = {m1_gnt, m0_gnt};
    assign we_v  = {m1_we, m0_we};

    // Per-master read return: capture memory data on a granted read, and
    // flag it valid the cycle after. A reset in that cycle kills the pulse.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ret
            localparam owner_e OWNER_ID = (gi == M_CPU) ? OWN_M0 : OWN_M1;

            logic [DW-1:0] rdata_d;
            logic [DW-1:0] rdata_q;

            // Load new data only on this master's granted read.
            always_comb begin
                rdata_d = rdata_q;
                if (gnt_v[gi] && is_read(we_v[gi])) begin
                    rdata_d = drdata;
                end
            end

            // Read-data register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q <= '0;
                end else begin
                    rdata_q <= rdata_d;
                end
            end

            assign rvalid_v[gi] = ~rst & rd_q & (owner_q == OWNER_ID);
        end
    endgenerate

    assign m0_rdata  = g_ret[M_CPU].rdata_q;
    assign m1_rdata  = g_ret[M_LDR].rdata_q;
    assign m0_rvalid = rvalid_v[M_CPU];
    assign m1_rvalid = rvalid_v[M_LDR];

endmodule
